dual_port_memory: RTL and testbench
===================================

Name: dual_port_memory

Overview:
- True dual-port synchronous RAM: 2^ADDR words of DATA bits, two independent read/write ports (A, B) on one clock.
- Storage is register-based so the whole array clears on reset.
- Generic scratch/shared storage between two masters in the datapath. Each port does one read or one write per cycle.

Parameters:
- ADDR, 4, address width in bits; depth = 2^ADDR words.
- DATA, 8, word width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_wr  input  1  port A write enable (1 = write, 0 = read).
- a_addr  input  ADDR  port A word address.
- a_din  input  DATA  port A write data.
- a_dout  output  DATA  port A registered read data.
- b_wr  input  1  port B write enable.
- b_addr  input  ADDR  port B word address.
- b_din  input  DATA  port B write data.
- b_dout  output  DATA  port B registered read data.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0):
  - Immediately, without a clock edge, every memory word becomes 0 and a_dout = b_dout = 0.
  - Held while rst_n=0; writes are ignored during reset.
  - Reset asserted mid-operation discards any pending write.
- Operation starts on the first rising clk edge with rst_n=1.
- Port write (x_wr=1) at a rising edge: mem[x_addr] <= x_din.
- Port read, 1-cycle latency: at each rising edge, x_dout <= mem[x_addr] (value before this edge's writes).
- Same-port write (write-first): x_dout <= x_din, so a port reads back what it writes in the same cycle.
- Both ports write the same address in one cycle: port A wins, so mem gets a_din.
  - a_dout = a_din.
  - b_dout = a_din, reflecting the stored value.
- Cross-port read/write collision (one port reads address X while the other writes X): reader gets the old contents of X (read-before-write).
  - The new value is visible to that reader from the next cycle.
- Different addresses: ports are fully independent; no stalls and no ordering constraints.
- Dout holds its last value only until the next edge; it updates every cycle from the current address (no read enable).
- X/Z on x_wr is treated as no write. No other error flags.
- Address wrap: addresses are exactly ADDR bits, so no out-of-range case; address 2^ADDR-1 is a valid last word.

Test Plan:
- Reset clear: write 0xA5 to A[3], assert rst_n=0 asynchronously between edges.
  - a_dout and b_dout go to 0x00 at once.
  - After release, read addr 3 on B → 0x00.
- Basic R/W latency:
  - A writes 0x3C to addr 5 at edge n.
  - B reads addr 5 at edge n+1 → b_dout = 0x3C after edge n+1.
  - A reads addr 5 → a_dout = 0x3C.
- Write-first same port: A writes 0x11 to addr 2 → a_dout = 0x11 after that same edge.
- Cross-port collision:
  - mem[7]=0x22; A writes 0x99 to 7 while B reads 7 → b_dout = 0x22.
  - Next cycle B reads 7 → 0x99.
- Dual write conflict: A writes 0xAA and B writes 0xBB to addr 0 in the same cycle → subsequent read of addr 0 on either port returns 0xAA.
- Full sweep / boundary:
  - A writes addr i with value i^0x5A for i=0..15.
  - Meanwhile B writes addr 15-i with 0xFF only where addresses differ.
  - Read all 16 on both ports and match the model, including addr 15 (0x55 from A's last write where not overwritten).

Source files
------------

// File: rtl/dual_port_memory_if.sv
// Bus bundle for the two-port RAM: per-port write enable, address, write data and read data.
interface dual_port_memory_if #(
  parameter int ADDR = 4,
  parameter int DATA = 8
);
  logic            a_wr;
  logic [ADDR-1:0] a_addr;
  logic [DATA-1:0] a_din;
  logic [DATA-1:0] a_dout;
  logic            b_wr;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_din;
  logic [DATA-1:0] b_dout;

  modport master (
    output a_wr, a_addr, a_din, b_wr, b_addr, b_din,
    input  a_dout, b_dout
  );

  modport slave (
    input  a_wr, a_addr, a_din, b_wr, b_addr, b_din,
    output a_dout, b_dout
  );
endinterface

// File: rtl/dual_port_memory.sv
// True dual-port register-file RAM: write-first on the writing port, read-before-write
// across ports, port A wins a same-address double write; whole array clears on reset.
module dual_port_memory #(
  parameter int ADDR = 4,
  parameter int DATA = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dual_port_memory_if.slave   bus
);
  localparam int DEPTH = 32'd1 << ADDR;

  logic [DATA-1:0] mem_q [DEPTH];
  logic [DATA-1:0] mem_d [DEPTH];
  logic [DATA-1:0] a_dout_q;
  logic [DATA-1:0] a_dout_d;
  logic [DATA-1:0] b_dout_q;
  logic [DATA-1:0] b_dout_d;
  logic            a_we_s;
  logic            b_we_s;
  logic            same_addr_s;

  // An unknown enable compares as non-true and falls into the no-write branches.
  always_comb begin
    a_we_s      = 1'b0;
    b_we_s      = 1'b0;
    same_addr_s = 1'b0;
    a_dout_d    = '0;
    b_dout_d    = '0;
    mem_d       = mem_q;

    if (bus.a_wr == 1'b1) begin
      a_we_s = 1'b1;
    end else begin
      a_we_s = 1'b0;
    end
    if (bus.b_wr == 1'b1) begin
      b_we_s = 1'b1;
    end else begin
      b_we_s = 1'b0;
    end
    same_addr_s = (bus.a_addr == bus.b_addr);

    for (int i = 0; i < DEPTH; i++) begin
      if (a_we_s && (bus.a_addr == ADDR'(i))) begin
        mem_d[i] = bus.a_din;
      end else if (b_we_s && (bus.b_addr == ADDR'(i))) begin
        mem_d[i] = bus.b_din;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end

    if (a_we_s) begin
      a_dout_d = bus.a_din;
    end else begin
      a_dout_d = mem_q[bus.a_addr];
    end

    // B reports what actually lands in the array, so a lost double write shows A's data.
    if (b_we_s && a_we_s && same_addr_s) begin
      b_dout_d = bus.a_din;
    end else if (b_we_s) begin
      b_dout_d = bus.b_din;
    end else begin
      b_dout_d = mem_q[bus.b_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      mem_q    <= mem_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign bus.a_dout = a_dout_q;
  assign bus.b_dout = b_dout_q;
endmodule

// File: tb/tb_dual_port_memory.sv
// Directed bench for dual_port_memory with hand-computed expectations and a small array model.
module tb_dual_port_memory;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  logic [7:0] model [16];

  dual_port_memory_if #(.ADDR(4), .DATA(8)) bus ();

  dual_port_memory #(.ADDR(4), .DATA(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic awr, input logic [3:0] aaddr, input logic [7:0] adin,
                     input logic bwr, input logic [3:0] baddr, input logic [7:0] bdin);
    @(negedge clk);
    bus.a_wr   = awr;
    bus.a_addr = aaddr;
    bus.a_din  = adin;
    bus.b_wr   = bwr;
    bus.b_addr = baddr;
    bus.b_din  = bdin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n      = 1'b0;
    bus.a_wr   = 1'b0;
    bus.a_addr = 4'd0;
    bus.a_din  = 8'h00;
    bus.b_wr   = 1'b0;
    bus.b_addr = 4'd0;
    bus.b_din  = 8'h00;
    #12;
    check("reset_a_dout", bus.a_dout, 8'h00);
    check("reset_b_dout", bus.b_dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clear
    cyc(1'b1, 4'd3, 8'hA5, 1'b0, 4'd3, 8'h00);
    check("wr3_a_dout", bus.a_dout, 8'hA5);
    cyc(1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00);
    check("rd3_b_dout", bus.b_dout, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", bus.a_dout, 8'h00);
    check("async_rst_b", bus.b_dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 8'h00);
    check("post_rst_b3", bus.b_dout, 8'h00);

    // Basic latency
    cyc(1'b1, 4'd5, 8'h3C, 1'b0, 4'd5, 8'h00);
    check("wr5_a", bus.a_dout, 8'h3C);
    check("wr5_b_old", bus.b_dout, 8'h00);
    cyc(1'b0, 4'd5, 8'h00, 1'b0, 4'd5, 8'h00);
    check("rd5_a", bus.a_dout, 8'h3C);
    check("rd5_b", bus.b_dout, 8'h3C);

    // Write-first on same port
    cyc(1'b1, 4'd2, 8'h11, 1'b0, 4'd0, 8'h00);
    check("wf_a2", bus.a_dout, 8'h11);
    check("wf_b0", bus.b_dout, 8'h00);

    // Cross-port collision
    cyc(1'b1, 4'd7, 8'h22, 1'b0, 4'd2, 8'h00);
    check("pre7_b2", bus.b_dout, 8'h11);
    cyc(1'b1, 4'd7, 8'h99, 1'b0, 4'd7, 8'h00);
    check("coll_b_old", bus.b_dout, 8'h22);
    check("coll_a_new", bus.a_dout, 8'h99);
    cyc(1'b0, 4'd2, 8'h00, 1'b0, 4'd7, 8'h00);
    check("coll_b_next", bus.b_dout, 8'h99);

    // Dual write conflict
    cyc(1'b1, 4'd0, 8'hAA, 1'b1, 4'd0, 8'hBB);
    check("dw_a", bus.a_dout, 8'hAA);
    check("dw_b", bus.b_dout, 8'hAA);
    cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    check("dw_rd_a", bus.a_dout, 8'hAA);
    check("dw_rd_b", bus.b_dout, 8'hAA);
    cyc(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h44);
    check("wf_b4", bus.b_dout, 8'h44);

    // Unknown write enable must not write
    cyc(1'bx, 4'd5, 8'hEE, 1'b0, 4'd5, 8'h00);
    check("x_wr_a", bus.a_dout, 8'h3C);
    cyc(1'b0, 4'd5, 8'h00, 1'b0, 4'd5, 8'h00);
    check("x_wr_b", bus.b_dout, 8'h3C);

    // Full sweep
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      automatic logic [3:0] ai = 4'(i);
      automatic logic [3:0] bi = 4'(15 - i);
      automatic logic [7:0] av = 8'(i) ^ 8'h5A;
      cyc(1'b1, ai, av, (ai != bi), bi, 8'hFF);
      if (ai != bi) model[bi] = 8'hFF;
      model[ai] = av;
      check("sweep_wr_a", bus.a_dout, av);
      check("sweep_wr_b", bus.b_dout, 8'hFF);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 4'(i), 8'h00, 1'b0, 4'(15 - i), 8'h00);
      check("sweep_rd_a", bus.a_dout, model[i]);
      check("sweep_rd_b", bus.b_dout, model[15 - i]);
    end
    cyc(1'b0, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00);
    check("last_word_a15", bus.a_dout, 8'h55);
    check("first_word_b0", bus.b_dout, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
